thor2021_ins_align: RTL and testbench
=====================================

Name: thor2021_ins_align

Overview:
- Instruction aligner / fetch byte queue between the I-cache fetch port and the instruction-length decoder / decode stage.
- Accepts 16-byte fetch lines and buffers them as a byte stream.
- Presents the head 8 bytes as the candidate instruction and receives that instruction's length (2/4/6/8 bytes) back from the length decoder.
- Retires exactly that many bytes per decode handshake and tracks the PC of the head byte.

Parameters:
- BUF_BYTES, 32, buffer capacity in bytes; multiple of 16, minimum 32.
- AWID, 32, PC width.
- RESET_PC, 32'hFFFC0000, PC loaded at reset; bits [3:0] even.

Ports:
- rst_i  in  1  asynchronous active-high reset.
- clk_i  in  1  clock.
- flush_i  in  1  redirect (branch/exception); discard the buffer.
- flush_pc_i  in  AWID  new PC on flush; bit 0 is 0.
- fetch_valid_i  in  1  fetch line valid.
- fetch_ready_o  out  1  buffer can take a 16-byte line.
- fetch_data_i  in  128  fetch line, little-endian; byte 0 = bits [7:0].
- ins_o  out  64  head 8 bytes of the buffer; opcode byte = ins_o[7:0]. Feeds the length decoder.
- ins_len_i  in  4  length of ins_o in bytes, from the length decoder (combinational on ins_o).
- ins_pc_o  out  AWID  PC of ins_o byte 0.
- ins_valid_o  out  1  a complete instruction is at the head.
- ins_ready_i  in  1  decode consumes the head instruction.
- count_o  out  6  bytes currently buffered.

Behaviour:
- Reset (async, asserted immediately):
  - count = 0; buffer bytes = 0; ins_pc = RESET_PC; skip = RESET_PC[3:0].
  - Outputs: ins_valid_o = 0, fetch_ready_o = 1, ins_o = 0, count_o = 0, ins_pc_o = RESET_PC.
- Length sanitising: eff_len = ins_len_i if it is 2, 4, 6 or 8; otherwise 2.
- ins_valid_o = (count >= 2) && (count >= eff_len).
  - Combinational from registered count, registered ins_o, and ins_len_i.
  - Not gated by flush_i.
- fetch_ready_o = (count <= BUF_BYTES-16). Depends on registered state only, not on ins_ready_i, so there is no combinational path from decode to fetch.
- Handshakes:
  - Consume: ins_valid_o && ins_ready_i.
  - Fill: fetch_valid_i && fetch_ready_o.
  - Both take effect at the same clock edge.
- Consume:
  - Buffer shifts down by eff_len bytes.
  - ins_pc += eff_len (wraps modulo 2^AWID).
  - count -= eff_len.
- Fill:
  - Line bytes skip..15 are written at byte position (count minus consumed bytes) in the post-consume buffer.
  - count += 16 - skip; skip then clears to 0.
  - Simultaneous consume + fill must produce the same result as consume followed by fill.
- Skip: a line-offset discard applied to the first fill after reset or flush, so a mid-line target starts the stream at the correct byte.
- Flush has highest priority:
  - Next state: count = 0, ins_pc = flush_pc_i, skip = flush_pc_i[3:0].
  - Any consume or fill presented in the flush cycle is discarded. Upstream refetches the line containing flush_pc_i.
- Empty-slot rule: bytes at positions >= count read as 0 on ins_o. A zero opcode byte decodes as BRK, length 2, but ins_valid_o still requires count >= 2.
- Full: when count > BUF_BYTES-16, fetch_ready_o = 0. Any fetch_valid_i that cycle is ignored, and upstream holds data until ready.
- No other state: the block is always RUN. The flush/skip register is its only mode.
- Latency:
  - A filled line is visible on ins_o / ins_valid_o the cycle after the fill edge.
  - Back-to-back consumes sustain one instruction per clock while count >= eff_len.
- count width of 6 bits covers BUF_BYTES up to 48. Assertion: count never exceeds BUF_BYTES.

Test Plan:
- Reset, fill line bytes 0x00..0x0F with ins_ready_i = 0 → next cycle: count_o = 16, ins_o = 64'h0706050403020100, ins_pc_o = RESET_PC, ins_valid_o = 1; fetch_ready_o stays 1 (16 <= 16).
- Mixed lengths: ins_len_i driven 2, 4, 8, 6 across four consecutive consumes from a 32-byte buffer → ins_pc_o advances +2, +4, +8, +6; count_o goes 30, 26, 18, 12; ins_o[7:0] equals buffer bytes 0, 2, 6, 14.
- Simultaneous consume (len 6) and fill with count = 10 → count_o = 20; bytes 6..9 now at positions 0..3; new line occupies positions 4..19.
- Partial instruction: count = 4, ins_len_i = 8 → ins_valid_o = 0; after the next fill, ins_valid_o = 1 and the 8-byte ins_o spans both lines correctly.
- Flush to pc 0x1006 while a fill and a consume are presented → both discarded; count_o = 0, ins_pc_o = 0x1006. The next fill drops 6 bytes: count_o = 10, ins_o[7:0] = line byte 6.
- Full/illegal length: BUF_BYTES = 32, count = 18 → fetch_ready_o = 0. ins_len_i = 4'd5 → consume retires 2 bytes and ins_pc_o += 2. Async reset asserted mid-stream → outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/thor2021_ins_align.sv
// Instruction aligner: buffers 16-byte fetch lines as a byte stream, presents the
// head 8 bytes to the length decoder, and retires 2/4/6/8 bytes per decode handshake
// while tracking the PC of the head byte.
module thor2021_ins_align #(
    parameter int unsigned     BUF_BYTES = 32,
    parameter int unsigned     AWID      = 32,
    parameter logic [AWID-1:0] RESET_PC  = AWID'(32'hFFFC0000)
) (
    input  logic            rst_i,
    input  logic            clk_i,
    input  logic            flush_i,
    input  logic [AWID-1:0] flush_pc_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [127:0]    fetch_data_i,
    output logic [63:0]     ins_o,
    input  logic [3:0]      ins_len_i,
    output logic [AWID-1:0] ins_pc_o,
    output logic            ins_valid_o,
    input  logic            ins_ready_i,
    output logic [5:0]      count_o
);

    localparam int unsigned BufBits   = BUF_BYTES * 8;
    localparam logic [5:0]  FillLimit = 6'(BUF_BYTES - 16);

    // Bytes at positions >= count are always held at zero, so the head window
    // can be read straight from the register without masking.
    logic [BufBits-1:0] buf_q, buf_d;
    logic [5:0]         count_q, count_d;
    logic [AWID-1:0]    pc_q, pc_d;
    logic [3:0]         skip_q, skip_d;

    logic [3:0]         eff_len;
    logic               consume;
    logic               fill;
    logic [5:0]         retire;
    logic [5:0]         keep;
    logic [BufBits-1:0] buf_shifted;
    logic [127:0]       line_aligned;
    logic [BufBits-1:0] line_placed;

    // Sanitise the decoded length: anything other than 2/4/6/8 retires 2 bytes.
    always_comb begin
        eff_len = 4'd2;
        case (ins_len_i)
            4'd2, 4'd4, 4'd6, 4'd8: eff_len = ins_len_i;
            default:                eff_len = 4'd2;
        endcase
    end

    assign ins_valid_o   = (count_q >= 6'd2) && (count_q >= {2'b00, eff_len});
    // Registered-state only, so decode never combinationally gates fetch.
    assign fetch_ready_o = (count_q <= FillLimit);

    assign consume = ins_valid_o && ins_ready_i;
    assign fill    = fetch_valid_i && fetch_ready_o;

    assign retire       = consume ? {2'b00, eff_len} : 6'd0;
    assign keep         = count_q - retire;
    assign buf_shifted  = buf_q >> {retire, 3'b000};
    // Drop the leading skip bytes of the line, then append it after the kept bytes.
    assign line_aligned = fetch_data_i >> {skip_q, 3'b000};
    assign line_placed  = {{(BufBits - 128){1'b0}}, line_aligned} << {keep, 3'b000};

    // Next state: flush wins; otherwise consume first, then append the fill.
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        pc_d    = pc_q;
        skip_d  = skip_q;
        if (flush_i) begin
            buf_d   = '0;
            count_d = 6'd0;
            pc_d    = flush_pc_i;
            skip_d  = flush_pc_i[3:0];
        end else begin
            buf_d   = buf_shifted;
            count_d = keep;
            pc_d    = pc_q + AWID'(retire);
            if (fill) begin
                buf_d   = buf_shifted | line_placed;
                count_d = keep + (6'd16 - {2'b00, skip_q});
                skip_d  = 4'd0;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q   <= '0;
            count_q <= 6'd0;
            pc_q    <= RESET_PC;
            skip_q  <= RESET_PC[3:0];
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            skip_q  <= skip_d;
        end
    end

    assign ins_o    = buf_q[63:0];
    assign ins_pc_o = pc_q;
    assign count_o  = count_q;

    count_in_range_a : assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= 6'(BUF_BYTES));

endmodule

// File: tb/tb_thor2021_ins_align.sv
// Directed bench for the instruction aligner with hand-computed expectations.
module tb_thor2021_ins_align;

    logic         rst_i;
    logic         clk_i;
    logic         flush_i;
    logic [31:0]  flush_pc_i;
    logic         fetch_valid_i;
    logic         fetch_ready_o;
    logic [127:0] fetch_data_i;
    logic [63:0]  ins_o;
    logic [3:0]   ins_len_i;
    logic [31:0]  ins_pc_o;
    logic         ins_valid_o;
    logic         ins_ready_i;
    logic [5:0]   count_o;

    int n_checks;
    int n_pass;

    thor2021_ins_align #(
        .BUF_BYTES(32),
        .AWID     (32),
        .RESET_PC (32'hFFFC0000)
    ) dut (
        .rst_i        (rst_i),
        .clk_i        (clk_i),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .fetch_valid_i(fetch_valid_i),
        .fetch_ready_o(fetch_ready_o),
        .fetch_data_i (fetch_data_i),
        .ins_o        (ins_o),
        .ins_len_i    (ins_len_i),
        .ins_pc_o     (ins_pc_o),
        .ins_valid_o  (ins_valid_o),
        .ins_ready_i  (ins_ready_i),
        .count_o      (count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Line whose byte i holds base+i.
    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[i*8 +: 8] = base + 8'(i);
        return l;
    endfunction

    // Advance one clock and step just past the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_i = 1'b1; flush_i = 1'b0; flush_pc_i = '0;
        fetch_valid_i = 1'b0; fetch_data_i = '0;
        ins_len_i = 4'd2; ins_ready_i = 1'b0;
        #3;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(ins_valid_o), 64'd0);
        check("rst_ready", 64'(fetch_ready_o), 64'd1);
        check("rst_ins", ins_o, 64'd0);
        check("rst_pc", 64'(ins_pc_o), 64'hFFFC0000);
        tick();
        rst_i = 1'b0;

        // First line, no consume.
        fetch_valid_i = 1'b1; fetch_data_i = mk_line(8'h00);
        tick();
        fetch_valid_i = 1'b0;
        #1;
        check("fill1_count", 64'(count_o), 64'd16);
        check("fill1_ins", ins_o, 64'h0706050403020100);
        check("fill1_pc", 64'(ins_pc_o), 64'hFFFC0000);
        check("fill1_valid", 64'(ins_valid_o), 64'd1);
        check("fill1_ready", 64'(fetch_ready_o), 64'd1);

        // Second line fills the buffer to 32.
        fetch_valid_i = 1'b1; fetch_data_i = mk_line(8'h10);
        tick();
        fetch_valid_i = 1'b0;
        #1;
        check("fill2_count", 64'(count_o), 64'd32);
        check("full32_ready", 64'(fetch_ready_o), 64'd0);

        // Mixed lengths 2, 4, 8, 6.
        ins_ready_i = 1'b1; ins_len_i = 4'd2;
        tick();
        check("c2_pc", 64'(ins_pc_o), 64'hFFFC0002);
        check("c2_count", 64'(count_o), 64'd30);
        check("c2_op", 64'(ins_o[7:0]), 64'h02);
        ins_len_i = 4'd4;
        tick();
        check("c4_pc", 64'(ins_pc_o), 64'hFFFC0006);
        check("c4_count", 64'(count_o), 64'd26);
        check("c4_op", 64'(ins_o[7:0]), 64'h06);
        ins_len_i = 4'd8;
        tick();
        check("c8_pc", 64'(ins_pc_o), 64'hFFFC000E);
        check("c8_count", 64'(count_o), 64'd18);
        check("c8_op", 64'(ins_o[7:0]), 64'h0E);
        check("full18_ready", 64'(fetch_ready_o), 64'd0);
        ins_len_i = 4'd6;
        tick();
        check("c6_pc", 64'(ins_pc_o), 64'hFFFC0014);
        check("c6_count", 64'(count_o), 64'd12);
        check("c6_op", 64'(ins_o[7:0]), 64'h14);
        check("c6_ready", 64'(fetch_ready_o), 64'd1);

        // Illegal length retires 2.
        ins_len_i = 4'd5;
        tick();
        check("bad_pc", 64'(ins_pc_o), 64'hFFFC0016);
        check("bad_count", 64'(count_o), 64'd10);
        check("bad_op", 64'(ins_o[7:0]), 64'h16);

        // Consume 6 and fill together at count 10.
        ins_len_i = 4'd6; fetch_valid_i = 1'b1; fetch_data_i = mk_line(8'h20);
        tick();
        fetch_valid_i = 1'b0;
        check("cf_count", 64'(count_o), 64'd20);
        check("cf_ins", ins_o, 64'h232221201F1E1D1C);
        check("cf_pc", 64'(ins_pc_o), 64'hFFFC001C);

        // Drain to 4 bytes, then a partial 8-byte instruction.
        ins_len_i = 4'd8;
        tick();
        tick();
        ins_ready_i = 1'b0;
        #1;
        check("part_count", 64'(count_o), 64'd4);
        check("part_pc", 64'(ins_pc_o), 64'hFFFC002C);
        check("part_valid", 64'(ins_valid_o), 64'd0);
        check("part_ins", ins_o, 64'h000000002F2E2D2C);
        fetch_valid_i = 1'b1; fetch_data_i = mk_line(8'h30);
        tick();
        fetch_valid_i = 1'b0;
        #1;
        check("span_valid", 64'(ins_valid_o), 64'd1);
        check("span_ins", ins_o, 64'h333231302F2E2D2C);
        check("span_count", 64'(count_o), 64'd20);

        // Flush beats a simultaneous fill and consume.
        flush_i = 1'b1; flush_pc_i = 32'h0000_1006;
        fetch_valid_i = 1'b1; fetch_data_i = mk_line(8'h50);
        ins_ready_i = 1'b1; ins_len_i = 4'd2;
        tick();
        flush_i = 1'b0; fetch_valid_i = 1'b0; ins_ready_i = 1'b0;
        #1;
        check("fl_count", 64'(count_o), 64'd0);
        check("fl_pc", 64'(ins_pc_o), 64'h1006);
        check("fl_ins", ins_o, 64'd0);
        check("fl_valid", 64'(ins_valid_o), 64'd0);
        fetch_valid_i = 1'b1; fetch_data_i = mk_line(8'h40);
        tick();
        fetch_valid_i = 1'b0;
        check("skip_count", 64'(count_o), 64'd10);
        check("skip_ins", ins_o, 64'h4D4C4B4A49484746);
        check("skip_pc", 64'(ins_pc_o), 64'h1006);

        // Asynchronous reset between edges.
        rst_i = 1'b1;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_pc", 64'(ins_pc_o), 64'hFFFC0000);
        check("arst_ins", ins_o, 64'd0);
        check("arst_valid", 64'(ins_valid_o), 64'd0);
        check("arst_ready", 64'(fetch_ready_o), 64'd1);
        tick();
        rst_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
